// File: rtl/ad_pkg.sv
// ad_pkg: shared defaults, widths and FSM encoding for the ADC sample controller.
package ad_pkg;
  localparam int CLK_DIV_DEF = 4;
  localparam int DECIM_DEF = 1;
  localparam int SMP_W = 12;
  localparam int PAD_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/ad_clk_gen.sv
// ad_clk_gen: free-running divider producing the registered ADC clock plus capture and wrap strobes.
module ad_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic ad_clk,
  output logic cap,
  output logic wrap
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_cnt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      div_cnt <= '0;
      ad_clk <= 1'b0;
    end else begin
      div_cnt <= div_cnt == LAST ? '0 : div_cnt + 1'b1;
      ad_clk <= div_cnt < HALF;
    end
  // ad_clk falls on the edge where div_cnt == HALF, which is where data is taken
  assign cap = div_cnt == HALF;
  assign wrap = div_cnt == LAST;
endmodule

// File: rtl/ad_sample_ctrl.sv
// ad_sample_ctrl: captures ADC samples on ad_clk falling edge, decimates, and emits each as a high/low byte pair.
module ad_sample_ctrl
  import ad_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DECIM = DECIM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SMP_W-1:0] ad_data,
  input  logic             ad_otr,
  output logic             ad_clk,
  output logic [7:0]       wr_data,
  output logic             wr_en,
  output logic [15:0]      sample_cnt,
  output logic             ovr_flag
);
  state_t state, state_nxt;
  logic cap, wrap, take, fwd, entry, pend_lo;
  logic [7:0] dec_cnt, lo_byte;
  ad_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .rst_n(rst_n),
    .ad_clk(ad_clk),
    .cap(cap),
    .wrap(wrap)
  );
  assign take = state == RUN && en && cap;
  assign fwd = take && dec_cnt == 8'd0;
  assign entry = state == IDLE && en && wrap;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // pend_lo marks a high byte already on the bus whose low byte must still follow
  always_comb
    state_nxt = state == IDLE ? (entry ? RUN : IDLE) :
                state == RUN  ? (en ? RUN : pend_lo ? DRAIN : IDLE) :
                (pend_lo ? DRAIN : IDLE);
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_en <= 1'b0;
      wr_data <= '0;
      pend_lo <= 1'b0;
      lo_byte <= '0;
      sample_cnt <= '0;
      ovr_flag <= 1'b0;
      dec_cnt <= '0;
    end else begin
      wr_en <= fwd || pend_lo;
      wr_data <= fwd ? {{PAD_W{1'b0}}, ad_data[SMP_W-1:8]} : pend_lo ? lo_byte : wr_data;
      pend_lo <= fwd;
      if (fwd) lo_byte <= ad_data[7:0];
      if (entry) begin
        sample_cnt <= '0;
        ovr_flag <= 1'b0;
        dec_cnt <= '0;
      end else begin
        if (pend_lo) sample_cnt <= sample_cnt + 16'd1;
        if (fwd && ad_otr) ovr_flag <= 1'b1;
        if (take) dec_cnt <= dec_cnt == 8'(DECIM - 1) ? 8'd0 : dec_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_ad_sample_ctrl.sv
// tb_ad_sample_ctrl: directed checks of byte pairing, ad_clk, decimation, overflow flag, wrap and reset abort.
module tb_ad_sample_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ad_otr = 1'b0;
  logic [11:0] ad_data = 12'hABC;
  logic a_clk, a_wr_en, a_ovr, b_clk, b_wr_en, b_ovr;
  logic [7:0] a_wr_data, b_wr_data;
  logic [15:0] a_cnt, b_cnt;
  int errors = 0, checks = 0, pulses = 0;
  always #5 clk = ~clk;
  ad_sample_ctrl #(.CLK_DIV(4), .DECIM(1)) d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ad_data(ad_data), .ad_otr(ad_otr),
    .ad_clk(a_clk), .wr_data(a_wr_data), .wr_en(a_wr_en), .sample_cnt(a_cnt), .ovr_flag(a_ovr)
  );
  ad_sample_ctrl #(.CLK_DIV(8), .DECIM(3)) d8 (
    .clk(clk), .rst_n(rst_n), .en(en), .ad_data(ad_data), .ad_otr(ad_otr),
    .ad_clk(b_clk), .wr_data(b_wr_data), .wr_en(b_wr_en), .sample_cnt(b_cnt), .ovr_flag(b_ovr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pair_hi(input string tag, input logic [7:0] hi);
    chk({tag, "_hi_en"}, 32'(a_wr_en), 32'd1);
    chk({tag, "_hi"}, 32'(a_wr_data), 32'(hi));
  endtask
  task automatic pair_lo(input string tag, input logic [7:0] lo, input logic [15:0] cnt);
    chk({tag, "_lo_en"}, 32'(a_wr_en), 32'd1);
    chk({tag, "_lo"}, 32'(a_wr_data), 32'(lo));
    chk({tag, "_cnt"}, 32'(a_cnt), 32'(cnt));
  endtask
  task automatic idle2(input string tag);
    tick();
    chk({tag, "_gap1"}, 32'(a_wr_en), 32'd0);
    tick();
    chk({tag, "_gap2"}, 32'(a_wr_en), 32'd0);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_wr_en", 32'(a_wr_en), 32'd0);
    chk("rst_wr_data", 32'(a_wr_data), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_ovr", 32'(a_ovr), 32'd0);
    chk("rst_ad_clk", 32'(a_clk), 32'd0);
    chk("rst_b_wr_en", 32'(b_wr_en), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    chk("adclk_e1", 32'(a_clk), 32'd1);
    tick();
    chk("adclk_e2", 32'(a_clk), 32'd1);
    tick();
    chk("adclk_e3", 32'(a_clk), 32'd0);
    tick();
    chk("adclk_e4", 32'(a_clk), 32'd0);
    chk("entry_no_wr", 32'(a_wr_en), 32'd0);
    tick();
    chk("adclk_e5", 32'(a_clk), 32'd1);
    tick();
    chk("pre_cap_no_wr", 32'(a_wr_en), 32'd0);
    tick();
    pair_hi("p1", 8'h0A);
    tick();
    pair_lo("p1", 8'hBC, 16'd1);
    idle2("p1");
    tick();
    pair_hi("p2", 8'h0A);
    tick();
    pair_lo("p2", 8'hBC, 16'd2);
    ad_data = 12'h123;
    ad_otr = 1'b1;
    idle2("p2");
    tick();
    pair_hi("otr", 8'h01);
    chk("ovr_set", 32'(a_ovr), 32'd1);
    tick();
    pair_lo("otr", 8'h23, 16'd3);
    ad_data = 12'h456;
    ad_otr = 1'b0;
    idle2("otr");
    tick();
    pair_hi("p4", 8'h04);
    chk("ovr_held_hi", 32'(a_ovr), 32'd1);
    tick();
    pair_lo("p4", 8'h56, 16'd4);
    chk("ovr_held_lo", 32'(a_ovr), 32'd1);
    idle2("p4");
    tick();
    pair_hi("drop", 8'h04);
    en = 1'b0;
    tick();
    pair_lo("drop", 8'h56, 16'd5);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("drop_quiet", 32'(a_wr_en), 32'd0);
    end
    en = 1'b1;
    tick();
    tick();
    chk("ovr_idle_held", 32'(a_ovr), 32'd1);
    chk("cnt_idle_held", 32'(a_cnt), 32'd5);
    tick();
    chk("ovr_clr_entry", 32'(a_ovr), 32'd0);
    chk("cnt_clr_entry", 32'(a_cnt), 32'd0);
    idle2("reentry");
    tick();
    pair_hi("wrap", 8'h04);
    force d4.sample_cnt = 16'hFFFF;
    #1;
    release d4.sample_cnt;
    chk("wrap_pre", 32'(a_cnt), 32'hFFFF);
    tick();
    pair_lo("wrap", 8'h56, 16'h0000);
    idle2("wrap");
    tick();
    pair_hi("abort", 8'h04);
    rst_n = 1'b0;
    tick();
    chk("abort_wr_en", 32'(a_wr_en), 32'd0);
    chk("abort_wr_data", 32'(a_wr_data), 32'd0);
    chk("abort_cnt", 32'(a_cnt), 32'd0);
    chk("abort_ovr", 32'(a_ovr), 32'd0);
    chk("abort_ad_clk", 32'(a_clk), 32'd0);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("restart_e1", 32'(a_clk), 32'd1);
    chk("abort_no_lo", 32'(a_wr_en), 32'd0);
    tick();
    chk("restart_e2", 32'(a_clk), 32'd1);
    tick();
    chk("restart_e3", 32'(a_clk), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_quiet", 32'(a_wr_en), 32'd0);
    end
    rst_n = 1'b0;
    tick();
    chk("b_rst_cnt", 32'(b_cnt), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 240; i++) begin
      tick();
      if (b_wr_en) pulses++;
    end
    chk("decim_pulses", 32'(pulses), 32'd20);
    chk("decim_cnt", 32'(b_cnt), 32'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
